// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: widths, opcode classes
// and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_2BYTE = 4'hC;

  typedef enum logic [0:0] {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

  // True when the opcode byte is followed by an immediate byte.
  function automatic logic is_2byte_op(input logic [DATA_W-1:0] op);
    return op[7:4] == OP_2BYTE;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush, then immediate capture for a
// pending 2-byte instruction, then load of a new opcode byte, else hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] fetch_byte,
  input  logic [ADDR_W-1:0] fetch_pc_plus1,
  output logic [DATA_W-1:0] instr_D,
  output logic [DATA_W-1:0] imm_D,
  output logic [ADDR_W-1:0] pc_plus1_D,
  output logic              valid_D,
  output logic              is_2byte_D
);

  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [ADDR_W-1:0] pc_plus1_reg;
  logic              valid_reg;
  logic              imm_have_reg;

  // Decode is waiting on the immediate byte of a 2-byte opcode.
  assign is_2byte_D = valid_reg & is_2byte_op(instr_reg) & ~imm_have_reg;

  // Register update with flush > capture > load > hold priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg    <= '0;
      imm_reg      <= '0;
      pc_plus1_reg <= '0;
      valid_reg    <= 1'b0;
      imm_have_reg <= 1'b0;
    end else if (flush) begin
      instr_reg    <= {OP_NOP, 4'h0};
      valid_reg    <= 1'b0;
      imm_have_reg <= 1'b0;
    end else if (is_2byte_D) begin
      imm_reg      <= fetch_byte;
      imm_have_reg <= 1'b1;
    end else if (load) begin
      instr_reg    <= fetch_byte;
      pc_plus1_reg <= fetch_pc_plus1;
      valid_reg    <= 1'b1;
      imm_have_reg <= 1'b0;
    end
  end

  assign instr_D    = instr_reg;
  assign imm_D      = imm_reg;
  assign pc_plus1_D = pc_plus1_reg;
  assign valid_D    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, next-PC mux, optional boot-vector FSM and the
// IF/ID register. Define FETCH_BOOT_VECTOR_EN to load the initial PC from
// instruction memory address 8'h00 during a one-cycle BOOT state.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic              branch_taken_E,
  input  logic [ADDR_W-1:0] branch_target_E,
  input  logic              ret_valid_M,
  input  logic [ADDR_W-1:0] ret_pc_M,
  output logic [DATA_W-1:0] instr_D,
  output logic [DATA_W-1:0] imm_D,
  output logic [ADDR_W-1:0] pc_plus1_D,
  output logic              valid_D,
  output logic              is_2byte_D
);

`ifdef FETCH_BOOT_VECTOR_EN
  localparam fetch_state_e RESET_STATE = FS_BOOT;
`else
  localparam fetch_state_e RESET_STATE = FS_RUN;
`endif

  fetch_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic              run;
  logic              redirect;

  assign run       = (state_reg == FS_RUN);
  assign pc_plus1  = pc_reg + 8'd1;
  assign redirect  = ret_valid_M | branch_taken_E;
  assign imem_addr = run ? pc_reg : '0;

  // Next-PC mux: boot vector, then RET > branch > immediate capture > freeze > advance.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (!run) begin
`ifdef FETCH_BOOT_VECTOR_EN
      pc_next    = imem_data;
`endif
      state_next = FS_RUN;
    end else if (ret_valid_M) begin
      pc_next = ret_pc_M;
    end else if (branch_taken_E) begin
      pc_next = branch_target_E;
    end else if (is_2byte_D || stall_F) begin
      pc_next = pc_plus1;
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef FETCH_BOOT_VECTOR_EN
      pc_reg    <= '0;
`else
      pc_reg    <= RESET_PC;
`endif
      state_reg <= RESET_STATE;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
    end
  end

  // Redirect and hazard controls are ignored while booting.
  if_id_reg u_if_id_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (run & (flush_D | redirect)),
    .load           (run & stall_D),
    .fetch_byte     (imem_data),
    .fetch_pc_plus1 (pc_plus1),
    .instr_D        (instr_D),
    .imm_D          (imm_D),
    .pc_plus1_D     (pc_plus1_D),
    .valid_D        (valid_D),
    .is_2byte_D     (is_2byte_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with RESET_PC = 8'h10.
// Honours FETCH_BOOT_VECTOR_EN for the reset/boot checks.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall_F;
  logic       stall_D;
  logic       stall_F_drv = 1'b1;
  logic       stall_D_drv = 1'b1;
  logic       hz_mode = 1'b0;
  logic       flush_D = 1'b0;
  logic       branch_taken_E = 1'b0;
  logic [7:0] branch_target_E = 8'h00;
  logic       ret_valid_M = 1'b0;
  logic [7:0] ret_pc_M = 8'h00;
  logic [7:0] instr_D;
  logic [7:0] imm_D;
  logic [7:0] pc_plus1_D;
  logic       valid_D;
  logic       is_2byte_D;

  logic [7:0] mem [256];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];
  // Hazard unit model: freeze fetch and decode while the immediate is captured.
  assign stall_F = hz_mode ? ~is_2byte_D : stall_F_drv;
  assign stall_D = hz_mode ? ~is_2byte_D : stall_D_drv;

  fetch_stage #(.RESET_PC(8'h10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .flush_D         (flush_D),
    .branch_taken_E  (branch_taken_E),
    .branch_target_E (branch_target_E),
    .ret_valid_M     (ret_valid_M),
    .ret_pc_M        (ret_pc_M),
    .instr_D         (instr_D),
    .imm_D           (imm_D),
    .pc_plus1_D      (pc_plus1_D),
    .valid_D         (valid_D),
    .is_2byte_D      (is_2byte_D)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%02h exp=%02h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %02h", tag, got);
    end
  endtask

  // Taken branch with a Decode flush; returns at the following negedge.
  task automatic redirect_to(input logic [7:0] target);
    branch_taken_E  = 1'b1;
    branch_target_E = target;
    flush_D         = 1'b1;
    @(negedge clk);
    branch_taken_E  = 1'b0;
    flush_D         = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h40;
    mem[8'h10] = 8'h21; mem[8'h11] = 8'h32; mem[8'h12] = 8'h43;
    mem[8'h40] = 8'h55;
    mem[8'h50] = 8'hC4; mem[8'h51] = 8'h7E; mem[8'h52] = 8'hA5;
    mem[8'h60] = 8'hC1; mem[8'h61] = 8'h22;
    mem[8'h80] = 8'h11;
    mem[8'h33] = 8'h44;
    mem[8'hFF] = 8'h9A;

    // Reset state
    @(negedge clk);
    check("rst valid_D", {7'b0, valid_D}, 8'h00);
    check("rst instr_D", instr_D, 8'h00);
    check("rst imm_D", imm_D, 8'h00);
    check("rst pc_plus1_D", pc_plus1_D, 8'h00);
    check("rst is_2byte_D", {7'b0, is_2byte_D}, 8'h00);
    rst_n = 1'b1;

`ifdef FETCH_BOOT_VECTOR_EN
    check("boot imem_addr", imem_addr, 8'h00);
    @(negedge clk);
    check("boot pc from vector", imem_addr, 8'h40);
    check("boot valid_D", {7'b0, valid_D}, 8'h00);
    @(negedge clk);
    check("boot instr_D", instr_D, 8'h55);
    check("boot valid_D after", {7'b0, valid_D}, 8'h01);
`else
    check("rst imem_addr", imem_addr, 8'h10);
    @(negedge clk);
    check("seq instr0", instr_D, 8'h21);
    check("seq pc+1 0", pc_plus1_D, 8'h11);
    check("seq valid", {7'b0, valid_D}, 8'h01);
    @(negedge clk);
    check("seq instr1", instr_D, 8'h32);
    check("seq pc+1 1", pc_plus1_D, 8'h12);
    @(negedge clk);
    check("seq instr2", instr_D, 8'h43);
    check("seq pc+1 2", pc_plus1_D, 8'h13);
`endif

    // Two-byte instruction with hazard-unit freeze
    redirect_to(8'h50);
    check("2b redirect addr", imem_addr, 8'h50);
    hz_mode = 1'b1;
    @(negedge clk);
    check("2b opcode", instr_D, 8'hC4);
    check("2b is_2byte high", {7'b0, is_2byte_D}, 8'h01);
    check("2b fetch imm addr", imem_addr, 8'h51);
    @(negedge clk);
    check("2b is_2byte low", {7'b0, is_2byte_D}, 8'h00);
    check("2b imm_D", imm_D, 8'h7E);
    check("2b opcode held", instr_D, 8'hC4);
    check("2b pc +2", imem_addr, 8'h52);
    @(negedge clk);
    check("2b next instr", instr_D, 8'hA5);
    check("2b next pc+1", pc_plus1_D, 8'h53);

    // Redirect during immediate capture
    redirect_to(8'h60);
    @(negedge clk);
    check("cap is_2byte", {7'b0, is_2byte_D}, 8'h01);
    branch_taken_E  = 1'b1;
    branch_target_E = 8'h80;
    flush_D         = 1'b1;
    @(negedge clk);
    branch_taken_E  = 1'b0;
    flush_D         = 1'b0;
    check("cap valid_D", {7'b0, valid_D}, 8'h00);
    check("cap is_2byte", {7'b0, is_2byte_D}, 8'h00);
    check("cap imm discarded", imm_D, 8'h7E);
    check("cap imem_addr", imem_addr, 8'h80);
    @(negedge clk);
    check("cap target instr", instr_D, 8'h11);
    check("cap target valid", {7'b0, valid_D}, 8'h01);

    // RET beats branch
    ret_valid_M     = 1'b1;
    ret_pc_M        = 8'h33;
    branch_taken_E  = 1'b1;
    branch_target_E = 8'h99;
    @(negedge clk);
    ret_valid_M     = 1'b0;
    branch_taken_E  = 1'b0;
    check("ret wins pc", imem_addr, 8'h33);
    check("ret flush valid", {7'b0, valid_D}, 8'h00);
    @(negedge clk);
    check("ret instr", instr_D, 8'h44);

    // Freeze for three cycles
    hz_mode     = 1'b0;
    stall_F_drv = 1'b0;
    stall_D_drv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("frz pc", imem_addr, 8'h34);
      check("frz instr", instr_D, 8'h44);
    end

    // PC wrap
    stall_F_drv = 1'b1;
    stall_D_drv = 1'b1;
    redirect_to(8'hFF);
    check("wrap at FF", imem_addr, 8'hFF);
    @(negedge clk);
    check("wrap pc", imem_addr, 8'h00);
    check("wrap instr", instr_D, 8'h9A);
    check("wrap pc+1", pc_plus1_D, 8'h00);
    @(negedge clk);
    check("wrap next instr", instr_D, 8'h40);

    // Flush wins over IF/ID hold
    stall_F_drv = 1'b0;
    stall_D_drv = 1'b0;
    flush_D     = 1'b1;
    @(negedge clk);
    flush_D     = 1'b0;
    check("flush valid", {7'b0, valid_D}, 8'h00);
    check("flush instr", instr_D, 8'h00);
    check("flush pc held", imem_addr, 8'h01);

    // Reset during immediate capture
    stall_F_drv = 1'b1;
    stall_D_drv = 1'b1;
    redirect_to(8'h50);
    hz_mode = 1'b1;
    @(negedge clk);
    check("mid is_2byte", {7'b0, is_2byte_D}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid rst is_2byte", {7'b0, is_2byte_D}, 8'h00);
    check("mid rst valid", {7'b0, valid_D}, 8'h00);
    check("mid rst instr", instr_D, 8'h00);
    check("mid rst pc+1", pc_plus1_D, 8'h00);
`ifdef FETCH_BOOT_VECTOR_EN
    check("mid rst addr", imem_addr, 8'h00);
`else
    check("mid rst addr", imem_addr, 8'h10);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 8-bit pipelined core. It holds the PC, drives the instruction-memory read address, and assembles 2-byte instructions by capturing the immediate byte. It applies the hazard unit's freeze/flush controls and the branch/RET redirects, and presents the instruction to the Decode stage.

## Interface
Parameters:
- `RESET_PC`, 8'h00, PC value after reset when the boot vector is compiled out.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  8  instruction memory read address; combinational from state.
- `imem_data`  in  8  byte at `imem_addr`, same-cycle (asynchronous read).
- `stall_F`  in  1  PC write enable from hazard unit: 1 = advance, 0 = freeze.
- `stall_D`  in  1  IF/ID write enable: 1 = load, 0 = hold.
- `flush_D`  in  1  1 = clear IF/ID to NOP.
- `branch_taken_E`  in  1  taken branch/JMP/CALL/LOOP resolved in Execute.
- `branch_target_E`  in  8  redirect target for a taken branch.
- `ret_valid_M`  in  1  RET/RTI return address available in Memory stage.
- `ret_pc_M`  in  8  popped return address.
- `instr_D`  out  8  opcode byte in Decode.
- `imm_D`  out  8  second (immediate) byte; valid once captured.
- `pc_plus1_D`  out  8  address after the instruction (CALL return address).
- `valid_D`  out  1  IF/ID holds a real instruction.
- `is_2byte_D`  out  1  Decode holds a 2-byte instruction whose immediate is not yet captured.

## Operation
- 2-byte opcodes are `instr_D[7:4] == OP_2BYTE` (4'hC).
- `is_2byte_D = valid_D & (instr_D[7:4]==OP_2BYTE) & ~imm_have`.
- `imem_addr` = `PC`. In BOOT state it is 8'h00.
- PC update priority, highest first:
  - `ret_valid_M` -> `ret_pc_M`.
  - `branch_taken_E` -> `branch_target_E`.
  - `is_2byte_D` (immediate capture) -> PC+1. This overrides `stall_F`=0.
  - `stall_F`=0 -> hold.
  - Otherwise PC+1. Wraps 8'hFF -> 8'h00.
- IF/ID update priority:
  - `flush_D`, `ret_valid_M` or `branch_taken_E` -> `valid_D`=0, `instr_D`=8'h00, `imm_have`=0.
  - `is_2byte_D` -> `imm_D`<=`imem_data`, `imm_have`<=1, other fields held.
  - `stall_D`=1 -> `instr_D`<=`imem_data`, `pc_plus1_D`<=PC+1, `valid_D`<=1, `imm_have`<=0.
  - Otherwise hold.
- A 2-byte instruction therefore costs one extra cycle. The hazard unit sees `is_2byte_D`, freezes and bubbles Execute. The next cycle `is_2byte_D` drops and the instruction proceeds with `imm_D`.
- A redirect arriving in the capture cycle wins. The immediate is discarded and `imm_have` is cleared.
- FSM: BOOT, RUN. BOOT exists only with the macro (see Configuration); otherwise the block is reset directly into RUN.

## Timing
- Reset values (async, `rst_n`=0):
  - PC=`RESET_PC`.
  - `instr_D`=8'h00, `imm_D`=8'h00, `pc_plus1_D`=8'h00.
  - `valid_D`=0, `imm_have`=0, `is_2byte_D`=0.
  - state=BOOT with the macro, else RUN.
- Fetch-to-Decode latency: 1 cycle. A byte at `imem_addr` in cycle n is on `instr_D` in n+1.
- Redirect: the target is on `imem_addr` the cycle after `branch_taken_E`/`ret_valid_M`, and in `instr_D` one cycle later.
- Simultaneous `ret_valid_M` and `branch_taken_E`: RET wins.
- Reset asserted mid-capture or mid-boot: all state returns to the reset values immediately. There is no partial immediate.
- `stall_D`=0 with `flush_D`=1: flush wins.

## Configuration
- `FETCH_BOOT_VECTOR_EN` defined:
  - After reset the FSM is in BOOT for exactly one cycle.
  - `imem_addr`=8'h00, PC<=`imem_data`, IF/ID stays invalid, then RUN.
  - All redirect and hazard inputs are ignored during BOOT.
  - `RESET_PC` is unused.
- Not defined: no BOOT state. Fetching starts at `RESET_PC` on the first clock after reset release.

## Structure
- Shared package `cpu_pkg`:
  - `OP_NOP`=4'h0, `OP_2BYTE`=4'hC.
  - `ADDR_W`=8, `DATA_W`=8.
  - Fetch FSM state enum (`FS_BOOT`, `FS_RUN`).
- Sub-module `if_id_reg`: the IF/ID register with flush/load/imm-capture priority.
- The PC, FSM and next-PC mux stay in `fetch_stage`.

## Test plan
- Reset, macro off, `RESET_PC`=8'h10, all enables 1, mem[10..12]=8'h21,8'h32,8'h43 -> `instr_D` = 8'h21, 8'h32, 8'h43 on consecutive cycles, `pc_plus1_D` = 8'h11, 8'h12, 8'h13.
- Macro on, mem[0]=8'h40, mem[40]=8'h55 -> BOOT for one cycle, then `imem_addr`=8'h40, then `instr_D`=8'h55, `valid_D`=1.
- Fetch 8'hC4 followed by immediate 8'h7E, with the hazard unit model driving `stall_F`/`stall_D`=0 while `is_2byte_D` -> `is_2byte_D` high exactly 1 cycle, then `imm_D`=8'h7E, PC advanced by 2 total, next `instr_D` = byte after the immediate.
- `branch_taken_E`=1 with target 8'h80 and `flush_D`=1 in the same cycle as an immediate capture -> `valid_D`=0, `imm_have`=0, `imem_addr`=8'h80 the next cycle.
- `ret_valid_M` with 8'h33 and `branch_taken_E` with 8'h99 simultaneously -> PC=8'h33.
- `stall_F`=0, `stall_D`=0 for 3 cycles -> PC and `instr_D` unchanged. PC at 8'hFF, advancing -> wraps to 8'h00.
